german_trace_recorder: RTL and testbench
========================================

# german_trace_recorder

Hardware trace recorder for the German coherence `system`. Each clock it samples the rule-select vector `io_en_a` that the environment presents to `system`, a fired flag, and a 10-bit digest of directory state. Consecutive identical samples are run-length compressed. Compressed entries are buffered and streamed out over a valid/ready port, so a hardware run can be rebuilt as a replayable stimulus trace.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, at least 2.
- `CNT_W`, 8: run-count width; maximum run length is 2^CNT_W−1.
- `DIGEST_W`, 10: digest width, fixed at 10 by the package packing.
- `clock` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous, active-low. Asserted when 0.
- `io_en_a` in 5: rule select presented to `system` this cycle.
- `io_fired` in 1: the selected rule's guard was true this cycle.
- `io_digest` in 10: {CurCmd[2:0], CurPtr[1:0], ExGntd, MemData[1:0], AuxData[1:0]}, MSB first.
- `io_arm` in 1: IDLE/DONE→ARMED; also clears `io_overflow`.
- `io_trigger` in 1: ARMED→CAPTURE.
- `io_stop` in 1: CAPTURE→DONE.
- `io_out_valid` out 1: head entry is available.
- `io_out_ready` in 1: consumer accepts the head entry.
- `io_out_bits` out CNT_W+16: {count, fired, en_a[4:0], digest[9:0]}.
- `io_state` out 2: IDLE=0, ARMED=1, CAPTURE=2, DONE=3.
- `io_overflow` out 1: sticky; a push was dropped.
- `io_count` out log2(DEPTH)+1: entries currently held in the FIFO.

## Operation
- Sample = {fired, en_a, digest}. A pending register holds (sample, count) for the current run, with a pending-valid bit.
- **IDLE**: no sampling. On `io_arm`: go to ARMED and clear overflow.
- **ARMED**: on `io_trigger`, capture the sample on that edge into pending with count=1, then go to CAPTURE.
- **CAPTURE**, each edge without `io_stop`:
  - Sample equals pending and count < max: count increments.
  - Otherwise: push pending to the FIFO, and load the new sample with count=1.
- **CAPTURE with `io_stop`**: the stop-cycle sample is not recorded. Pending is pushed, pending-valid clears, and the state goes to DONE.
- **Push when the FIFO is full and there is no pop the same edge**:
  - the entry is dropped;
  - `io_overflow` is set;
  - pending-valid clears;
  - the state goes to DONE.
- **Push when full with a pop the same edge**: accepted. `io_count` is unchanged.
- **DONE**: no sampling. The FIFO keeps draining. `io_arm` re-arms and clears overflow; FIFO contents are kept.
- `io_arm` is ignored in ARMED and CAPTURE. `io_trigger` is ignored outside ARMED. `io_stop` is ignored outside CAPTURE; `io_stop` in ARMED has no effect.
- A pop occurs on any edge with `io_out_valid && io_out_ready`.
- `io_out_bits` is the head entry. It must stay stable while valid and not ready.

## Timing
- Reset values (applied asynchronously, immediately on assertion):
  - `io_state`=IDLE, `io_out_valid`=0, `io_out_bits`=0, `io_overflow`=0, `io_count`=0;
  - pending-valid=0 and the FIFO is emptied.
- The first edge with `reset` deasserted behaves as a normal edge.
- A pushed entry raises `io_out_valid` on the cycle after the push edge (one-cycle latency). There is no combinational path from the inputs to `io_out_valid`.
- `io_count` updates on the same edge as the push or pop.
- A run longer than 2^CNT_W−1 splits into a saturated entry followed by the remainder.
- The count field never holds 0 in an emitted entry.

## Structure
- Package `german_trace_pkg` holds:
  - state enum;
  - `ENTRY_W`;
  - field offsets for count, fired, en_a and digest;
  - digest packing order.
- Sub-module `trace_fifo`:
  - synchronous, show-ahead FIFO with parameter `DEPTH`;
  - asynchronous active-low `reset`;
  - push/pop/full/empty/count;
  - simultaneous push and pop allowed when full.
- The top level holds the FSM, the pending register and the compression logic.

## Test plan
- **Reset**: assert `reset`=0 mid-cycle → all outputs 0 and `io_state`=0 before the next edge.
- **Basic run**:
  - stimulus: arm; trigger with en_a=5'b01001, fired=1, digest=10'h2A5 held for 3 cycles; then en_a=5'b00000 for 1 cycle; then stop;
  - response: two entries, {8'd3,1,5'b01001,10'h2A5} then {8'd1,…,5'b00000,…}, and state DONE.
- **Saturation**: 300 identical cycles then stop → entries with count 255 then 45.
- **Overflow**:
  - stimulus: `io_out_ready`=0, 18 distinct consecutive samples;
  - response: 16 entries held, `io_overflow`=1 on the edge of sample 18, state DONE, `io_count`=16;
  - drain: the 16 entries come out in order, and `io_arm` clears overflow.
- **Backpressure**: ready toggles every cycle while the FIFO is full and pushes continue → no drop, and head bits stay stable while stalled.
- **Reset mid-capture**: reset asserted in CAPTURE with 5 entries held → FIFO empty, IDLE, and no entry emitted afterwards.

Source files
------------

// File: rtl/german_trace_recorder_pkg.sv
// rtl/german_trace_recorder_pkg.sv - shared types and field layout for the German trace recorder
// Purpose: recorder state encoding, sample/entry field offsets, digest packing helper.
// Entry layout (MSB first): {count[CNT_W-1:0], fired, en_a[4:0], digest[9:0]}.
package german_trace_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  localparam int DIGEST_W  = 10;
  localparam int EN_A_W    = 5;
  localparam int SAMPLE_W  = 1 + EN_A_W + DIGEST_W;
  localparam int DEF_CNT_W = 8;
  localparam int ENTRY_W   = DEF_CNT_W + SAMPLE_W;

  // Field offsets inside an entry.
  localparam int DIGEST_LSB = 0;
  localparam int EN_A_LSB   = DIGEST_LSB + DIGEST_W;
  localparam int FIRED_BIT  = EN_A_LSB + EN_A_W;
  localparam int COUNT_LSB  = FIRED_BIT + 1;

  // Digest packing order: {CurCmd[2:0], CurPtr[1:0], ExGntd, MemData[1:0], AuxData[1:0]}.
  localparam int DIG_AUX_LSB  = 0;
  localparam int DIG_MEM_LSB  = 2;
  localparam int DIG_EXG_BIT  = 4;
  localparam int DIG_PTR_LSB  = 5;
  localparam int DIG_CMD_LSB  = 7;

  function automatic logic [DIGEST_W-1:0] pack_digest(
    input logic [2:0] cur_cmd,
    input logic [1:0] cur_ptr,
    input logic       ex_gntd,
    input logic [1:0] mem_data,
    input logic [1:0] aux_data
  );
    return {cur_cmd, cur_ptr, ex_gntd, mem_data, aux_data};
  endfunction

endpackage

// File: rtl/german_trace_recorder_if.sv
// rtl/german_trace_recorder_if.sv - valid/ready entry stream between recorder and consumer
// Purpose: carries compressed trace entries out of the recorder.
// Signals: io_out_valid (head available), io_out_ready (consumer accepts), io_out_bits (head entry).
// master = recorder side, slave = consumer side.
interface german_trace_recorder_if #(
  parameter int ENTRY_W = 24
);
  logic               io_out_valid;
  logic               io_out_ready;
  logic [ENTRY_W-1:0] io_out_bits;

  modport master (output io_out_valid, output io_out_bits, input io_out_ready);
  modport slave  (input io_out_valid, input io_out_bits, output io_out_ready);
endinterface

// File: rtl/german_trace_recorder_fifo.sv
// rtl/german_trace_recorder_fifo.sv - show-ahead synchronous FIFO for trace entries
// Purpose: buffers entries; head is visible on pop_data_o whenever not empty.
// Ports: clock, reset (async active-low), push_i/push_data_i, pop_i/pop_data_o,
//        full_o, empty_o, count_o (entries held).
// A push while full is accepted only if a pop happens on the same edge.
module trace_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 24
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           push_data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           pop_data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             wr_en, rd_en;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == FULL_CNT);
  assign rd_en   = pop_i && !empty_o;
  assign wr_en   = push_i && (!full_o || rd_en);
  // Force zero when empty so the head reads 0 straight out of reset.
  assign pop_data_o = empty_o ? '0 : mem_q[rd_ptr_q];
  assign count_o    = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/german_trace_recorder.sv
// rtl/german_trace_recorder.sv - run-length compressing trace recorder for the German protocol
// Purpose: samples {fired, en_a, digest} each capture cycle, merges identical runs,
//          buffers entries in trace_fifo and streams them out.
// Ports: clock, reset (async active-low); io_en_a/io_fired/io_digest sample inputs;
//        io_arm/io_trigger/io_stop control; out_if entry stream (master);
//        io_state, io_overflow (sticky drop flag), io_count (FIFO occupancy).
module german_trace_recorder
  import german_trace_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int CNT_W    = 8,
  parameter int DIGEST_W = 10
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [4:0]                io_en_a,
  input  logic                      io_fired,
  input  logic [DIGEST_W-1:0]       io_digest,
  input  logic                      io_arm,
  input  logic                      io_trigger,
  input  logic                      io_stop,
  german_trace_recorder_if.master   out_if,
  output logic [1:0]                io_state,
  output logic                      io_overflow,
  output logic [$clog2(DEPTH):0]    io_count
);
  localparam int SW = 1 + 5 + DIGEST_W;
  localparam int EW = CNT_W + SW;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e           state_q, state_d;
  logic [SW-1:0]    pend_sample_q, pend_sample_d;
  logic [CNT_W-1:0] pend_cnt_q, pend_cnt_d;
  logic             pend_vld_q, pend_vld_d;
  logic             ovf_q, ovf_d;

  logic [SW-1:0]    sample;
  logic             push;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [EW-1:0]    fifo_head;

  assign sample = {io_fired, io_en_a, io_digest};
  assign pop    = out_if.io_out_valid && out_if.io_out_ready;

  always_comb begin
    state_d       = state_q;
    pend_sample_d = pend_sample_q;
    pend_cnt_d    = pend_cnt_q;
    pend_vld_d    = pend_vld_q;
    ovf_d         = ovf_q;
    push          = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (io_arm) begin
          state_d = ST_ARMED;
          ovf_d   = 1'b0;
        end
      end
      ST_ARMED: begin
        if (io_trigger) begin
          pend_sample_d = sample;
          pend_cnt_d    = CNT_ONE;
          pend_vld_d    = 1'b1;
          state_d       = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        if (io_stop) begin
          // Stop-cycle sample is deliberately discarded; only the open run is flushed.
          push       = pend_vld_q;
          pend_vld_d = 1'b0;
          state_d    = ST_DONE;
        end else if (pend_vld_q && sample == pend_sample_q && pend_cnt_q != CNT_MAX) begin
          pend_cnt_d = pend_cnt_q + CNT_ONE;
        end else begin
          push          = pend_vld_q;
          pend_sample_d = sample;
          pend_cnt_d    = CNT_ONE;
          pend_vld_d    = 1'b1;
        end
        // A dropped push ends the capture: the trace is no longer contiguous.
        if (push && fifo_full && !pop) begin
          ovf_d      = 1'b1;
          pend_vld_d = 1'b0;
          state_d    = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      pend_sample_q <= '0;
      pend_cnt_q    <= '0;
      pend_vld_q    <= 1'b0;
      ovf_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      pend_sample_q <= pend_sample_d;
      pend_cnt_q    <= pend_cnt_d;
      pend_vld_q    <= pend_vld_d;
      ovf_q         <= ovf_d;
    end
  end

  trace_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clock       (clock),
    .reset       (reset),
    .push_i      (push),
    .push_data_i ({pend_cnt_q, pend_sample_q}),
    .pop_i       (out_if.io_out_ready),
    .pop_data_o  (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (io_count)
  );

  // Valid derives only from the registered occupancy, so inputs never reach it combinationally.
  assign out_if.io_out_valid = !fifo_empty;
  assign out_if.io_out_bits  = fifo_head;
  assign io_state            = state_q;
  assign io_overflow         = ovf_q;

endmodule

// File: tb/tb_german_trace_recorder.sv
// tb/tb_german_trace_recorder.sv - self-checking bench for german_trace_recorder
module tb_german_trace_recorder;
  import german_trace_pkg::*;

  localparam int DEPTH = 16;
  localparam int CNT_W = 8;
  localparam int EW    = CNT_W + 16;

  typedef logic [15:0]   sq_t[$];
  typedef logic [EW-1:0] eq_t[$];

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [4:0]  en_a = '0;
  logic        fired = 1'b0;
  logic [9:0]  digest = '0;
  logic        arm = 1'b0, trigger = 1'b0, stop = 1'b0;
  logic [1:0]  state;
  logic        ovf;
  logic [4:0]  cnt;

  german_trace_recorder_if #(.ENTRY_W(EW)) out_if ();

  german_trace_recorder #(.DEPTH(DEPTH), .CNT_W(CNT_W), .DIGEST_W(10)) dut (
    .clock       (clock),
    .reset       (reset),
    .io_en_a     (en_a),
    .io_fired    (fired),
    .io_digest   (digest),
    .io_arm      (arm),
    .io_trigger  (trigger),
    .io_stop     (stop),
    .out_if      (out_if.master),
    .io_state    (state),
    .io_overflow (ovf),
    .io_count    (cnt)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Stream monitor: collect popped entries and check head stability while stalled.
  eq_t           got_q;
  eq_t           exp_q;
  logic          prev_stall = 1'b0;
  logic [EW-1:0] prev_bits  = '0;

  always @(posedge clock) begin
    if (reset) begin
      if (prev_stall) begin
        chk("stall_valid", {31'd0, out_if.io_out_valid}, 32'd1);
        chk("stall_bits", {8'd0, out_if.io_out_bits}, {8'd0, prev_bits});
      end
      if (out_if.io_out_valid && out_if.io_out_ready) got_q.push_back(out_if.io_out_bits);
      prev_stall = out_if.io_out_valid && !out_if.io_out_ready;
      prev_bits  = out_if.io_out_bits;
    end else begin
      prev_stall = 1'b0;
    end
  end

  // Reference: split the recorded sample list into maximal runs, each emitted in
  // chunks of at most 2^CNT_W-1.
  task automatic build_expected(input sq_t s);
    int i, j, run, c;
    logic [CNT_W-1:0] c8;
    exp_q.delete();
    i = 0;
    while (i < s.size()) begin
      j = i;
      while (j < s.size() && s[j] == s[i]) j++;
      run = j - i;
      while (run > 0) begin
        c = (run > 255) ? 255 : run;
        c8 = c[CNT_W-1:0];
        exp_q.push_back({c8, s[i]});
        run -= c;
      end
      i = j;
    end
  endtask

  task automatic compare(input string tag);
    int n;
    chk($sformatf("%s_len", tag), got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int k = 0; k < n; k++)
      chk($sformatf("%s_e%0d", tag, k), {8'd0, got_q[k]}, {8'd0, exp_q[k]});
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_sample(input logic [15:0] s);
    {fired, en_a, digest} = s;
  endtask

  task automatic do_reset();
    @(posedge clock);
    #3;
    reset = 1'b0;
    #1;
    chk("rst_state", {30'd0, state}, 32'd0);
    chk("rst_valid", {31'd0, out_if.io_out_valid}, 32'd0);
    chk("rst_bits", {8'd0, out_if.io_out_bits}, 32'd0);
    chk("rst_ovf", {31'd0, ovf}, 32'd0);
    chk("rst_count", {27'd0, cnt}, 32'd0);
    arm = 0; trigger = 0; stop = 0;
    out_if.io_out_ready = 1'b0;
    set_sample('0);
    step();
    reset = 1'b1;
    got_q.delete();
  endtask

  task automatic capture(input sq_t s, input int ready_pct);
    arm = 1'b1;
    step();
    arm = 1'b0;
    for (int k = 0; k < s.size(); k++) begin
      set_sample(s[k]);
      trigger = (k == 0);
      out_if.io_out_ready = ($urandom_range(99) < ready_pct);
      step();
    end
    trigger = 1'b0;
    stop = 1'b1;
    out_if.io_out_ready = 1'b1;
    step();
    stop = 1'b0;
  endtask

  task automatic drain(input string tag);
    int i;
    out_if.io_out_ready = 1'b1;
    i = 0;
    while (i < 300 && cnt != 0) begin
      step();
      i++;
    end
    chk($sformatf("%s_drained", tag), {27'd0, cnt}, 32'd0);
    step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    sq_t s;
    logic [15:0] v;
    logic [15:0] alph[4];
    int len;
    out_if.io_out_ready = 1'b0;

    // Basic run.
    do_reset();
    s.delete();
    repeat (3) s.push_back({1'b1, 5'b01001, 10'h2A5});
    s.push_back({1'b0, 5'b00000, 10'h2A5});
    capture(s, 100);
    chk("basic_state", {30'd0, state}, {30'd0, ST_DONE});
    drain("basic");
    build_expected(s);
    compare("basic");
    chk("basic_first", {8'd0, got_q[0]}, {8'd0, 8'd3, 1'b1, 5'b01001, 10'h2A5});
    chk("basic_second", {8'd0, got_q[1]}, {8'd0, 8'd1, 1'b0, 5'b00000, 10'h2A5});

    // Saturation: 300 identical samples.
    do_reset();
    s.delete();
    v = 16'($urandom);
    repeat (300) s.push_back(v);
    capture(s, 100);
    drain("sat");
    build_expected(s);
    compare("sat");
    chk("sat_cnt0", {24'd0, got_q[0][23:16]}, 32'd255);
    chk("sat_cnt1", {24'd0, got_q[1][23:16]}, 32'd45);

    // Overflow: 18 distinct samples with no consumer.
    do_reset();
    s.delete();
    arm = 1'b1;
    step();
    arm = 1'b0;
    for (int k = 0; k < 18; k++) begin
      v = 16'(16'h1000 + k * 37);
      s.push_back(v);
      set_sample(v);
      trigger = (k == 0);
      step();
      if (k == 16) begin
        chk("ovf_pre_flag", {31'd0, ovf}, 32'd0);
        chk("ovf_pre_count", {27'd0, cnt}, 32'd16);
        chk("ovf_pre_state", {30'd0, state}, {30'd0, ST_CAPTURE});
      end
    end
    trigger = 1'b0;
    chk("ovf_flag", {31'd0, ovf}, 32'd1);
    chk("ovf_state", {30'd0, state}, {30'd0, ST_DONE});
    chk("ovf_count", {27'd0, cnt}, 32'd16);
    drain("ovf");
    s = s[0:15];
    build_expected(s);
    compare("ovf");
    chk("ovf_sticky", {31'd0, ovf}, 32'd1);
    arm = 1'b1;
    step();
    arm = 1'b0;
    chk("ovf_cleared", {31'd0, ovf}, 32'd0);
    chk("ovf_rearmed", {30'd0, state}, {30'd0, ST_ARMED});

    // Backpressure: full FIFO, ready toggling, pushes aligned to ready cycles.
    do_reset();
    s.delete();
    arm = 1'b1;
    step();
    arm = 1'b0;
    for (int k = 0; k < 17; k++) begin
      v = 16'(16'h4000 + k * 11);
      s.push_back(v);
      set_sample(v);
      trigger = (k == 0);
      step();
    end
    trigger = 1'b0;
    chk("bp_full", {27'd0, cnt}, 32'd16);
    for (int j = 0; j < 10; j++) begin
      v = 16'(16'h8000 + j * 13);
      set_sample(v);
      s.push_back(v);
      out_if.io_out_ready = 1'b1;
      step();
      chk("bp_count_pop", {27'd0, cnt}, 32'd16);
      s.push_back(v);
      out_if.io_out_ready = 1'b0;
      step();
      chk("bp_count_hold", {27'd0, cnt}, 32'd16);
      chk("bp_no_ovf", {31'd0, ovf}, 32'd0);
    end
    stop = 1'b1;
    out_if.io_out_ready = 1'b1;
    step();
    stop = 1'b0;
    chk("bp_stop_ovf", {31'd0, ovf}, 32'd0);
    drain("bp");
    build_expected(s);
    compare("bp");

    // Reset mid-capture with 5 entries held.
    do_reset();
    arm = 1'b1;
    step();
    arm = 1'b0;
    for (int k = 0; k < 6; k++) begin
      set_sample(16'(16'h2000 + k * 5));
      trigger = (k == 0);
      step();
    end
    trigger = 1'b0;
    chk("mid_count", {27'd0, cnt}, 32'd5);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_count", {27'd0, cnt}, 32'd0);
    chk("mid_rst_state", {30'd0, state}, 32'd0);
    chk("mid_rst_valid", {31'd0, out_if.io_out_valid}, 32'd0);
    chk("mid_rst_bits", {8'd0, out_if.io_out_bits}, 32'd0);
    step();
    reset = 1'b1;
    got_q.delete();
    out_if.io_out_ready = 1'b1;
    repeat (20) step();
    chk("mid_no_emit", got_q.size(), 32'd0);
    chk("mid_idle", {30'd0, state}, {30'd0, ST_IDLE});

    // Randomized runs over a small alphabet to create runs.
    for (int t = 0; t < 6; t++) begin
      do_reset();
      for (int a = 0; a < 4; a++)
        alph[a] = {1'($urandom), 5'($urandom),
                   pack_digest(3'($urandom), 2'($urandom), 1'($urandom), 2'($urandom), 2'($urandom))};
      len = $urandom_range(150, 40);
      s.delete();
      v = alph[0];
      for (int k = 0; k < len; k++) begin
        if ($urandom_range(3) == 0) v = alph[$urandom_range(3)];
        s.push_back(v);
      end
      capture(s, 75);
      chk($sformatf("rnd%0d_state", t), {30'd0, state}, {30'd0, ST_DONE});
      drain($sformatf("rnd%0d", t));
      build_expected(s);
      compare($sformatf("rnd%0d", t));
      chk($sformatf("rnd%0d_ovf", t), {31'd0, ovf}, 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
